// File: rtl/word_delivery_if.sv
// Bundle between the keystroke matcher (master) and the word supplier (slave).
interface word_delivery_if;
    logic        wordComplete;
    logic [19:0] currentWord;
    logic [19:0] nextWord;

    modport master (output wordComplete, input currentWord, input nextWord);
    modport slave  (input wordComplete, output currentWord, output nextWord);
endinterface

// File: rtl/word_delivery.sv
// Current/preview word supplier: promotes the preview on each rising wordComplete, draws a new one via LFSR-indexed ROM.
// Optional WORD_DELIVERY_NOREPEAT_EN: bumps the drawn index by one when it equals the index just promoted.
module word_delivery (
    input  logic              clk,
    input  logic              reset,
    word_delivery_if.slave    bus
);
    logic [19:0] cur_word_q, cur_word_d;
    logic [19:0] next_word_q, next_word_d;
    logic [4:0]  next_idx_q, next_idx_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        wc_q, wc_d;

    logic        advance;
    logic [7:0]  lfsr_step;
    logic [4:0]  cand;
    logic [4:0]  idx;

    // Packed as four 5-bit letters, first letter in the MSBs (A=1 .. Z=26).
    function automatic logic [19:0] rom_word(input logic [4:0] i);
        case (i)
            5'd0:    rom_word = {5'd3,  5'd15, 5'd4,  5'd5};   // CODE
            5'd1:    rom_word = {5'd23, 5'd15, 5'd18, 5'd4};   // WORD
            5'd2:    rom_word = {5'd7,  5'd1,  5'd20, 5'd5};   // GATE
            5'd3:    rom_word = {5'd6,  5'd16, 5'd7,  5'd1};   // FPGA
            5'd4:    rom_word = {5'd23, 5'd9,  5'd18, 5'd5};   // WIRE
            5'd5:    rom_word = {5'd2,  5'd25, 5'd20, 5'd5};   // BYTE
            5'd6:    rom_word = {5'd3,  5'd15, 5'd18, 5'd5};   // CORE
            5'd7:    rom_word = {5'd12, 5'd15, 5'd15, 5'd16};  // LOOP
            5'd8:    rom_word = {5'd14, 5'd1,  5'd14, 5'd4};   // NAND
            5'd9:    rom_word = {5'd2,  5'd9,  5'd20, 5'd19};  // BITS
            5'd10:   rom_word = {5'd2,  5'd21, 5'd19, 5'd25};  // BUSY
            5'd11:   rom_word = {5'd3,  5'd8,  5'd9,  5'd16};  // CHIP
            5'd12:   rom_word = {5'd4,  5'd1,  5'd20, 5'd1};   // DATA
            5'd13:   rom_word = {5'd5,  5'd4,  5'd7,  5'd5};   // EDGE
            5'd14:   rom_word = {5'd6,  5'd12, 5'd15, 5'd16};  // FLOP
            5'd15:   rom_word = {5'd8,  5'd1,  5'd12, 5'd20};  // HALT
            5'd16:   rom_word = {5'd10, 5'd21, 5'd13, 5'd16};  // JUMP
            5'd17:   rom_word = {5'd11, 5'd5,  5'd25, 5'd19};  // KEYS
            5'd18:   rom_word = {5'd12, 5'd15, 5'd1,  5'd4};   // LOAD
            5'd19:   rom_word = {5'd13, 5'd1,  5'd19, 5'd11};  // MASK
            5'd20:   rom_word = {5'd14, 5'd15, 5'd4,  5'd5};   // NODE
            5'd21:   rom_word = {5'd15, 5'd16, 5'd5,  5'd14};  // OPEN
            5'd22:   rom_word = {5'd16, 5'd15, 5'd18, 5'd20};  // PORT
            5'd23:   rom_word = {5'd18, 5'd5,  5'd1,  5'd4};   // READ
            5'd24:   rom_word = {5'd19, 5'd25, 5'd14, 5'd3};   // SYNC
            5'd25:   rom_word = {5'd20, 5'd1,  5'd19, 5'd11};  // TASK
            5'd26:   rom_word = {5'd21, 5'd14, 5'd9,  5'd20};  // UNIT
            5'd27:   rom_word = {5'd22, 5'd15, 5'd12, 5'd20};  // VOLT
            5'd28:   rom_word = {5'd24, 5'd15, 5'd18, 5'd19};  // XORS
            5'd29:   rom_word = {5'd26, 5'd5,  5'd18, 5'd15};  // ZERO
            5'd30:   rom_word = {5'd17, 5'd21, 5'd9,  5'd20};  // QUIT
            default: rom_word = {5'd19, 5'd12, 5'd15, 5'd23};  // SLOW
        endcase
    endfunction

    always_comb begin
        advance   = bus.wordComplete & ~wc_q;
        lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        cand      = lfsr_step[4:0];
`ifdef WORD_DELIVERY_NOREPEAT_EN
        idx       = (cand == next_idx_q) ? cand + 5'd1 : cand;
`else
        idx       = cand;
`endif
        cur_word_d  = cur_word_q;
        next_word_d = next_word_q;
        next_idx_d  = next_idx_q;
        lfsr_d      = lfsr_q;
        wc_d        = bus.wordComplete;
        if (advance) begin
            cur_word_d  = next_word_q;
            next_word_d = rom_word(idx);
            next_idx_d  = idx;
            lfsr_d      = lfsr_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_word_q  <= rom_word(5'd0);
            next_word_q <= rom_word(5'd1);
            next_idx_q  <= 5'd1;
            lfsr_q      <= 8'h01;
            wc_q        <= 1'b0;
        end else begin
            cur_word_q  <= cur_word_d;
            next_word_q <= next_word_d;
            next_idx_q  <= next_idx_d;
            lfsr_q      <= lfsr_d;
            wc_q        <= wc_d;
        end
    end

    assign bus.currentWord = cur_word_q;
    assign bus.nextWord    = next_word_q;
endmodule

// File: tb/tb_word_delivery.sv
// Directed bench for word_delivery: vector table for the pulse/hold sequences, hand sequences for reset corners.
module tb_word_delivery;
    logic clk = 1'b0;
    logic reset;
    word_delivery_if bus_if();

    word_delivery dut (.clk(clk), .reset(reset), .bus(bus_if.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic wc;
        int   cur_idx;
        int   nxt_idx;
    } vec_t;

    vec_t  vecs[$];
    int    n_vec = 0;
    int    n_bad = 0;
    string words[32] = '{"CODE","WORD","GATE","FPGA","WIRE","BYTE","CORE","LOOP",
                         "NAND","BITS","BUSY","CHIP","DATA","EDGE","FLOP","HALT",
                         "JUMP","KEYS","LOAD","MASK","NODE","OPEN","PORT","READ",
                         "SYNC","TASK","UNIT","VOLT","XORS","ZERO","QUIT","SLOW"};

    function automatic logic [19:0] pack(input string s);
        logic [19:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ch = s[i];
            r = {r[14:0], 5'(ch - 8'd64)};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, got, exp);
        end
    endtask

    task automatic check_words(input string name, input int ci, input int ni);
        check({name, " currentWord"}, bus_if.currentWord, pack(words[ci]));
        check({name, " nextWord"},    bus_if.nextWord,    pack(words[ni]));
        $display("%s: cur=%s next=%s -> 0x%05h 0x%05h", name, words[ci], words[ni],
                 bus_if.currentWord, bus_if.nextWord);
    endtask

    // Drive wordComplete mid-cycle, then sample 1 ns after the next rising edge.
    task automatic step(input logic wc);
        @(negedge clk);
        bus_if.wordComplete = wc;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic wc, input int c, input int n);
        vec_t v;
        v.wc = wc; v.cur_idx = c; v.nxt_idx = n;
        vecs.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected indices follow the LFSR from seed 0x01: 2, 4, 8, 17, 3, 7, 14, 28.
        add(1, 1, 2);   add(0, 1, 2);
        add(1, 2, 4);   add(0, 2, 4);
        add(1, 4, 8);   add(0, 4, 8);
        add(1, 8, 17);  add(0, 8, 17);
        add(1, 17, 3);  add(0, 17, 3);
        add(1, 3, 7);   add(0, 3, 7);
        for (int i = 0; i < 10; i++) add(1, 7, 14);
        add(0, 7, 14);
        add(1, 14, 28); add(0, 14, 28);

        reset = 1'b1;
        bus_if.wordComplete = 1'b0;
        #10;
        reset = 1'b0;
        #1;
        check("reset currentWord", bus_if.currentWord, 20'h1BC85);
        check("reset nextWord",    bus_if.nextWord,    20'hBBE44);
        step(0);
        check_words("idle after reset", 0, 1);

        foreach (vecs[k]) begin
            step(vecs[k].wc);
            check_words($sformatf("vec %0d wc=%0d", k, vecs[k].wc), vecs[k].cur_idx, vecs[k].nxt_idx);
        end

        // Asynchronous reset mid-run: takes effect between edges.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_words("async reset no edge", 0, 1);

        // wordComplete high while reset held: reset wins.
        step(1);
        check_words("reset with wc high", 0, 1);
        step(1);
        check_words("reset with wc high 2", 0, 1);

        // Release with wordComplete still high: first edge advances, once.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_words("wc high at release", 1, 2);
        step(1);
        check_words("wc still high", 1, 2);
        step(0);
        step(1);
        check_words("pulse after reset run", 2, 4);

`ifdef WORD_DELIVERY_NOREPEAT_EN
        // Next candidate is 8; preload nextIdx to 8 to force a collision.
        @(negedge clk);
        bus_if.wordComplete = 1'b0;
        force dut.next_idx_q = 5'd8;
        #1;
        release dut.next_idx_q;
        step(1);
        check("norepeat nextIdx", 20'(dut.next_idx_q), 20'd9);
        check("norepeat nextWord", bus_if.nextWord, pack(words[9]));
        n_vec++;
        if (bus_if.nextWord === pack(words[4])) begin
            n_bad++;
            $display("FAIL norepeat differs: got 0x%05h must differ from 0x%05h",
                     bus_if.nextWord, pack(words[4]));
        end
        step(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
